// File: rtl/jtkcpu_memctrl.sv
// Byte-serial memory controller: maps 8/16-bit CPU accesses onto an 8-bit bus, big-endian.
// Optional bus timeout abort is built when JTKCPU_BUSTOUT_EN is defined.
module jtkcpu_memctrl #(
    parameter logic [7:0] TOUT = 8'd255
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        req,
    input  logic        we,
    input  logic        wide,
    input  logic [15:0] addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        busy,
    output logic        done,
    output logic        buserror,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        bus_cs,
    output logic        bus_wr,
    input  logic        bus_ok
);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t      state, state_nxt;
    logic        we_l, wide_l;
    logic [15:0] addr_l;
    logic [7:0]  din_lo;
    logic        accept, byte_ok, last, abort, tout_hit;

    // busy covers the request cycle itself so the CPU stalls without a bubble
    assign busy = ~rst & ((state == IDLE) ? req : 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= IDLE;
        else if (cen) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        byte_ok   = 1'b0;
        last      = 1'b0;
        abort     = 1'b0;
        if (cen) begin
            unique case (state)
                IDLE: if (req) begin
                    accept    = 1'b1;
                    state_nxt = HI;
                end
                HI: if (bus_ok) begin
                    byte_ok = 1'b1;
                    if (wide_l) state_nxt = LO;
                    else begin
                        last      = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (tout_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
                LO: if (bus_ok) begin
                    byte_ok   = 1'b1;
                    last      = 1'b1;
                    state_nxt = IDLE;
                end else if (tout_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_l     <= 1'b0;
            wide_l   <= 1'b0;
            addr_l   <= 16'h0000;
            din_lo   <= 8'h00;
            dout     <= 16'h0000;
            done     <= 1'b0;
            bus_cs   <= 1'b0;
            bus_wr   <= 1'b0;
            bus_addr <= 16'h0000;
            bus_dout <= 8'h00;
        end else if (cen) begin
            done <= last | abort;
            if (accept) begin
                we_l     <= we;
                wide_l   <= wide;
                addr_l   <= addr;
                din_lo   <= din[7:0];
                bus_cs   <= 1'b1;
                bus_wr   <= we;
                bus_addr <= addr;
                bus_dout <= wide ? din[15:8] : din[7:0];
            end
            // second byte of a wide access sits at the next address, wrapping at 64k
            if (byte_ok && state == HI && wide_l) begin
                bus_addr <= addr_l + 16'd1;
                bus_dout <= din_lo;
            end
            if (byte_ok && !we_l) begin
                if (state == LO)  dout[7:0]  <= bus_din;
                else if (wide_l)  dout[15:8] <= bus_din;
                else              dout       <= {8'h00, bus_din};
            end
            if (last || abort) begin
                bus_cs <= 1'b0;
                bus_wr <= 1'b0;
            end
        end
    end

`ifdef JTKCPU_BUSTOUT_EN
    logic [7:0] tcnt;

    // abort on the wait cycle that would bring the count up to TOUT
    assign tout_hit = bus_cs && (tcnt == TOUT - 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt     <= 8'h00;
            buserror <= 1'b0;
        end else if (cen) begin
            buserror <= abort;
            if (state == IDLE || byte_ok || abort) tcnt <= 8'h00;
            else if (!bus_ok)                      tcnt <= tcnt + 8'd1;
        end
    end
`else
    logic unused_tout;
    assign unused_tout = ^TOUT;
    assign tout_hit    = 1'b0;
    assign buserror    = 1'b0;
`endif

endmodule

// File: tb/tb_jtkcpu_memctrl.sv
// Directed bench for jtkcpu_memctrl: table of accesses plus hand sequences for
// busy-time requests, mid-access reset, cen freeze and the bus timeout.
module tb_jtkcpu_memctrl;

    logic        rst, clk, cen, req, we, wide, bus_ok;
    logic [15:0] addr, din, dout, bus_addr;
    logic [7:0]  bus_dout, bus_din;
    logic        busy, done, buserror, bus_cs, bus_wr;

    int checks = 0;
    int errors = 0;

`ifdef JTKCPU_BUSTOUT_EN
    localparam logic [7:0] TOUT_TB = 8'd4;
`else
    localparam logic [7:0] TOUT_TB = 8'd255;
`endif

    jtkcpu_memctrl #(.TOUT(TOUT_TB)) dut (
        .rst(rst), .clk(clk), .cen(cen), .req(req), .we(we), .wide(wide),
        .addr(addr), .din(din), .dout(dout), .busy(busy), .done(done),
        .buserror(buserror), .bus_addr(bus_addr), .bus_dout(bus_dout),
        .bus_din(bus_din), .bus_cs(bus_cs), .bus_wr(bus_wr), .bus_ok(bus_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic        wide;
        logic [15:0] addr;
        logic [15:0] din;
        logic [7:0]  d0, d1;    // bus byte per cycle: expected write byte or supplied read byte
        logic [15:0] a0, a1;    // expected bus address per byte
        int          waits;     // bus_ok=0 cycles inserted on the first byte
        logic [15:0] exp_dout;
        int          exp_lat;
    } vec_t;

    // Issue one access and follow it to done, checking every bus cycle.
    task automatic run_vec(input string tag, input vec_t v);
        int lat, nbyte, wcnt;
        logic w;
        @(negedge clk);
        req = 1'b1; we = v.we; wide = v.wide; addr = v.addr; din = v.din;
        #1 chk({tag, " busy_req"}, busy, 1'b1);
        @(negedge clk);
        req = 1'b0; addr = 16'h0000; din = 16'h0000;
        lat = 1; nbyte = 0; wcnt = 0;
        while (!done && lat < 40) begin
            if (bus_cs) begin
                w = (nbyte == 0) && (wcnt < v.waits);
                chk({tag, " bus_addr"}, bus_addr, (nbyte == 0) ? v.a0 : v.a1);
                chk({tag, " bus_wr"}, bus_wr, v.we);
                if (v.we) chk({tag, " bus_dout"}, bus_dout, (nbyte == 0) ? v.d0 : v.d1);
                bus_din = (nbyte == 0) ? v.d0 : v.d1;
                bus_ok  = ~w;
                if (w) wcnt++;
                else   nbyte++;
            end else begin
                bus_ok = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus_ok = 1'b0;
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " bytes"}, nbyte, v.wide ? 2 : 1);
        chk({tag, " dout"}, dout, v.exp_dout);
        chk({tag, " busy_end"}, busy, 1'b0);
        chk({tag, " cs_end"}, bus_cs, 1'b0);
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 1'b0);
    endtask

    vec_t vecs[6];

    initial begin
        int ndone, ncs;
        logic prev_cs;
        vec_t v;

        vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 8'h5A, 8'h00, 16'h1234, 16'h0000, 0, 16'h005A, 2};
        vecs[1] = '{1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 8'hBE, 8'hEF, 16'hFFFF, 16'h0000, 0, 16'h005A, 3};
        vecs[2] = '{1'b0, 1'b1, 16'h2000, 16'h0000, 8'h12, 8'h34, 16'h2000, 16'h2001, 2, 16'h1234, 5};
        vecs[3] = '{1'b1, 1'b0, 16'h00FF, 16'h00A5, 8'hA5, 8'h00, 16'h00FF, 16'h0000, 1, 16'h1234, 3};
        vecs[4] = '{1'b0, 1'b1, 16'h7FFE, 16'h0000, 8'h9C, 8'h01, 16'h7FFE, 16'h7FFF, 0, 16'h9C01, 3};
        vecs[5] = '{1'b0, 1'b0, 16'h4000, 16'h0000, 8'h77, 8'h00, 16'h4000, 16'h0000, 0, 16'h0077, 2};

        rst = 1'b1; cen = 1'b1; req = 1'b1; we = 1'b1; wide = 1'b0;
        addr = 16'hAAAA; din = 16'h5555; bus_din = 8'h00; bus_ok = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 1'b0);
        chk("rst bus_cs", bus_cs, 1'b0);
        chk("rst bus_wr", bus_wr, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst buserror", buserror, 1'b0);
        chk("rst dout", dout, 16'h0000);
        chk("rst bus_addr", bus_addr, 16'h0000);
        chk("rst bus_dout", bus_dout, 8'h00);
        req = 1'b0; we = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // bus_ok while idle does nothing
        bus_ok = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ok bus_cs", bus_cs, 1'b0);
        chk("idle_ok done", done, 1'b0);
        chk("idle_ok dout", dout, 16'h0077);
        bus_ok = 1'b0;

        // request during a busy wide read is dropped
        req = 1'b1; we = 1'b0; wide = 1'b1; addr = 16'h3000;
        ndone = 0; ncs = 0; prev_cs = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin req = 1'b1; addr = 16'h5555; end
            else req = 1'b0;
            if (done) ndone++;
            if (bus_cs && !prev_cs) ncs++;
            if (bus_cs) chk("busyreq addr", bus_addr == 16'h5555 || bus_addr == 16'h5556, 1'b0);
            prev_cs = bus_cs;
            bus_din = 8'hC3; bus_ok = 1'b1;
        end
        bus_ok = 1'b0;
        chk("busyreq dones", ndone, 1);
        chk("busyreq cycles", ncs, 1);
        chk("busyreq dout", dout, 16'hC3C3);

        // reset in the second byte of a wide read
        @(negedge clk);
        req = 1'b1; we = 1'b0; wide = 1'b1; addr = 16'h6000;
        @(negedge clk);
        req = 1'b0; bus_ok = 1'b1; bus_din = 8'h11;
        @(negedge clk);
        bus_ok = 1'b0;
        chk("rstLO state_cs", bus_cs, 1'b1);
        chk("rstLO addr", bus_addr, 16'h6001);
        rst = 1'b1; req = 1'b1;
        #1;
        chk("rstLO bus_cs", bus_cs, 1'b0);
        chk("rstLO busy", busy, 1'b0);
        chk("rstLO dout", dout, 16'h0000);
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        v = '{1'b0, 1'b0, 16'hABCD, 16'h0000, 8'hE1, 8'h00, 16'hABCD, 16'h0000, 0, 16'h00E1, 2};
        run_vec("after_rst", v);

        // cen low holds the done pulse
        @(negedge clk);
        req = 1'b1; we = 1'b1; wide = 1'b0; addr = 16'h0100; din = 16'h0042;
        @(negedge clk);
        req = 1'b0; bus_ok = 1'b1;
        @(negedge clk);
        bus_ok = 1'b0;
        chk("cen done", done, 1'b1);
        cen = 1'b0;
        repeat (3) @(negedge clk);
        chk("cen hold done", done, 1'b1);
        chk("cen hold cs", bus_cs, 1'b0);
        cen = 1'b1;
        @(negedge clk);
        chk("cen release done", done, 1'b0);

        // stalled bus: abort with the timeout, or wait forever without it
        @(negedge clk);
        req = 1'b1; we = 1'b0; wide = 1'b0; addr = 16'h0800; bus_ok = 1'b0;
        @(negedge clk);
        req = 1'b0;
`ifdef JTKCPU_BUSTOUT_EN
        begin
            int lat;
            lat = 1;
            while (!done && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk("tout latency", lat, 5);
            chk("tout done", done, 1'b1);
            chk("tout buserror", buserror, 1'b1);
            chk("tout bus_cs", bus_cs, 1'b0);
            chk("tout dout", dout, 16'h00E1);
            chk("tout busy", busy, 1'b0);
            @(negedge clk);
            chk("tout pulse", done | buserror, 1'b0);
        end
`else
        begin
            int ndn;
            ndn = 0;
            repeat (300) begin
                @(negedge clk);
                if (done || buserror) ndn++;
            end
            chk("stall no_done", ndn, 0);
            chk("stall bus_cs", bus_cs, 1'b1);
            chk("stall busy", busy, 1'b1);
            chk("stall addr", bus_addr, 16'h0800);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("stall rst cs", bus_cs, 1'b0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtkcpu_memctrl.md
JTKCPU_MEMCTRL -- requirements
Module: jtkcpu_memctrl

Interface
REQ-001 Parameter: TOUT, 8'd255, cen-qualified cycles of wait before an access is aborted (used only with the Configuration macro).
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 clk  in  1  clock.
REQ-004 cen  in  1  clock enable; all state changes only on clk edges with cen=1.
REQ-005 req  in  1  access request from CPU control; sampled only in IDLE.
REQ-006 we  in  1  1=write, 0=read; latched with req.
REQ-007 wide  in  1  1=16-bit access, 0=8-bit; latched with req.
REQ-008 addr  in  16  access address; latched with req.
REQ-009 din  in  16  write data; latched with req.
REQ-010 dout  out  16  read data, big-endian assembled.
REQ-011 busy  out  1  access in progress (the CPU's mem_busy).
REQ-012 done  out  1  one-cen-cycle pulse at access completion.
REQ-013 buserror  out  1  one-cen-cycle pulse on timeout abort.
REQ-014 bus_addr  out  16  external byte address.
REQ-015 bus_dout  out  8  external write byte.
REQ-016 bus_din  in  8  external read byte.
REQ-017 bus_cs  out  1  external cycle strobe.
REQ-018 bus_wr  out  1  external write strobe, valid while bus_cs=1.
REQ-019 bus_ok  in  1  external ready; completes the current byte cycle when sampled high with cen.

Function
REQ-020 FSM states: IDLE, HI, LO; HI is the first byte of a wide access or the only byte of a narrow one.
REQ-021 IDLE: req=1 with cen latches we/wide/addr/din and enters HI; bus_cs, bus_wr and bus_addr are registered and valid from the next cycle.
REQ-022 busy = req in IDLE, or state != IDLE, combinationally, so busy is high in the request cycle.
REQ-023 HI, wide: bus_addr=addr, bus_dout=din[15:8], a read stores bus_din into dout[15:8]; bus_ok moves to LO.
REQ-024 LO: bus_addr=addr+1 mod 2^16 (FFFF wraps to 0000), bus_dout=din[7:0], a read stores bus_din into dout[7:0].
REQ-025 HI, narrow: bus_addr=addr, bus_dout=din[7:0], a read stores bus_din into dout[7:0] and clears dout[15:8] to 00.
REQ-026 On the final bus_ok, drop bus_cs/bus_wr, pulse done on the next cen cycle and return to IDLE; busy falls with the done pulse.
REQ-027 Latency with bus_ok tied high: narrow = done 2 cen cycles after req; wide = 3.
REQ-028 Each bus_ok=0 cycle adds one cen cycle to the current byte; bus_addr, bus_dout and bus_wr stay stable.
REQ-029 req while busy is ignored and not queued.
REQ-030 A write leaves dout unchanged.
REQ-031 bus_ok outside bus_cs is ignored.
REQ-032 cen=0 freezes all state and outputs; done and buserror stay asserted until the next cen cycle.

Reset
REQ-033 rst immediately forces IDLE, bus_cs=0, bus_wr=0, done=0, buserror=0, busy=0 (req ignored), dout=0000, bus_addr=0000, bus_dout=00 and the timeout counter to 0, including mid-access.
REQ-034 After rst release, the first req is accepted on the first cen edge.

Configuration
REQ-035 Macro JTKCPU_BUSTOUT_EN defined: an 8-bit counter counts cen cycles with bus_cs=1 and bus_ok=0, and clears on each byte completion.
REQ-036 With the macro, the counter reaching TOUT aborts the access: bus_cs=0, buserror and done pulse together, dout is unchanged, and the FSM goes to IDLE.
REQ-037 Without the macro: no counter is built, buserror is constant 0, and the block waits indefinitely for bus_ok.

Verification
REQ-038 Narrow read: addr=1234, bus_ok=1, bus_din=5A -> bus_addr=1234 for one cycle, dout=005A, done 2 cycles after req.
REQ-039 Wide write with wrap: addr=FFFF, din=BEEF -> bytes BE @FFFF then EF @0000, bus_wr=1 for both, done 3 cycles after req.
REQ-040 Wide read with 2 waits on byte 1: bus_din 12 then 34 -> dout=1234, done 5 cycles after req, bus_addr stable during waits.
REQ-041 req pulse during a busy wide read -> ignored; exactly one done, and no second bus cycle.
REQ-042 rst asserted in LO -> bus_cs=0 and busy=0 in the same cycle; a new req after release completes normally.
REQ-043 JTKCPU_BUSTOUT_EN defined, TOUT=4, bus_ok=0 -> buserror and done pulse after 4 wait cycles, then IDLE; without the macro the access still waits after 300 cycles.
